// File: rtl/mvu_stream_sequencer.sv
// Stream-side control around the MVU compute core: buffers one activation vector,
// replays it across all neuron folds and registers finished result groups for output.
module mvu_stream_sequencer #(
  parameter int PE               = 2,
  parameter int SIMD             = 2,
  parameter int MW               = 4,
  parameter int MH               = 4,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACCU_WIDTH       = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]     s_w_tdata,
  input  logic                                s_w_tvalid,
  output logic                                s_w_tready,
  input  logic [SIMD*ACTIVATION_WIDTH-1:0]    s_a_tdata,
  input  logic                                s_a_tvalid,
  output logic                                s_a_tready,
  output logic [PE*ACCU_WIDTH-1:0]            m_tdata,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic                                core_en,
  output logic                                core_last,
  output logic                                core_zero,
  output logic [PE*SIMD*WEIGHT_WIDTH-1:0]     core_w,
  output logic [SIMD*ACTIVATION_WIDTH-1:0]    core_a,
  input  logic                                core_vld,
  input  logic [PE*ACCU_WIDTH-1:0]            core_p
);

  localparam int SF  = MW / SIMD;
  localparam int NF  = MH / PE;
  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
  localparam int AW  = SIMD * ACTIVATION_WIDTH;
  localparam int PW  = PE * ACCU_WIDTH;

  logic [SFW-1:0] sf_q, sf_d;
  logic [NFW-1:0] nf_q, nf_d;
  logic [AW-1:0]  abuf_q [SF];
  logic [PW-1:0]  m_tdata_q;
  logic           m_tvalid_q;

  logic stall, go, have_a, first_fold, sf_at_end, nf_at_end;

  assign stall      = m_tvalid_q & ~m_tready;
  assign core_en    = ~stall;
  assign first_fold = (nf_q == '0);
  assign sf_at_end  = (sf_q == SFW'(SF - 1));
  assign nf_at_end  = (nf_q == NFW'(NF - 1));
  assign have_a     = first_fold ? s_a_tvalid : 1'b1;
  // Gating with rst keeps both stream inputs closed while the core is being cleared.
  assign go         = ~rst & core_en & s_w_tvalid & have_a;

  assign s_w_tready = go;
  assign s_a_tready = go & first_fold;
  assign core_w     = s_w_tdata;
  assign core_a     = first_fold ? s_a_tdata : abuf_q[sf_q];
  assign core_zero  = ~go;
  assign core_last  = go & sf_at_end;

  always_comb begin
    sf_d = sf_q;
    nf_d = nf_q;
    if (go) begin
      if (sf_at_end) begin
        sf_d = '0;
        nf_d = nf_at_end ? '0 : nf_q + NFW'(1);
      end else begin
        sf_d = sf_q + SFW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sf_q <= '0;
      nf_q <= '0;
    end else begin
      sf_q <= sf_d;
      nf_q <= nf_d;
    end
  end

  // Buffer has no reset: every entry is rewritten in fold 0 before any later fold reads it.
  always_ff @(posedge clk) begin
    if (go && first_fold) begin
      abuf_q[sf_q] <= s_a_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else if (core_en && core_vld) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= core_p;
    end else if (m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_mvu_stream_sequencer.sv
// Directed bench for mvu_stream_sequencer with a behavioural 5-stage MVU core model.
module tb_mvu_stream_sequencer;

  localparam int PE = 2, SIMD = 2, MW = 4, MH = 4;
  localparam int AWID = 8, WWID = 8, ACC = 24;
  localparam int SF = MW / SIMD, NF = MH / PE;
  localparam int AW = SIMD * AWID, WW = PE * SIMD * WWID, PW = PE * ACC;
  localparam int VW = MW * AWID;

  logic clk = 0, rst = 1;
  logic [WW-1:0] s_w_tdata = '0;
  logic s_w_tvalid = 0, s_w_tready;
  logic [AW-1:0] s_a_tdata = '0;
  logic s_a_tvalid = 0, s_a_tready;
  logic [PW-1:0] m_tdata;
  logic m_tvalid, m_tready = 1;
  logic core_en, core_last, core_zero, core_vld;
  logic [WW-1:0] core_w;
  logic [AW-1:0] core_a;
  logic [PW-1:0] core_p;

  int checks = 0, errors = 0;
  logic [PW-1:0] exp_q [$];

  always #5 clk = ~clk;

  mvu_stream_sequencer #(.PE(PE), .SIMD(SIMD), .MW(MW), .MH(MH),
    .ACTIVATION_WIDTH(AWID), .WEIGHT_WIDTH(WWID), .ACCU_WIDTH(ACC)) dut (
    .clk(clk), .rst(rst),
    .s_w_tdata(s_w_tdata), .s_w_tvalid(s_w_tvalid), .s_w_tready(s_w_tready),
    .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .core_en(core_en), .core_last(core_last), .core_zero(core_zero),
    .core_w(core_w), .core_a(core_a), .core_vld(core_vld), .core_p(core_p));

  // Core model: signed weights times unsigned activations, result 5 enabled cycles after last.
  int            acc [PE];
  int            acc_sum [PE];
  logic [PW-1:0] res_pack;
  logic          pipe_v [5];
  logic [PW-1:0] pipe_d [5];

  function automatic int dot(input logic [WW-1:0] w, input logic [AW-1:0] a, input int pe);
    int s;
    s = 0;
    for (int k = 0; k < SIMD; k++)
      s += int'($signed(w[(pe*SIMD+k)*WWID +: WWID])) * int'(a[k*AWID +: AWID]);
    return s;
  endfunction

  always_comb begin
    res_pack = '0;
    for (int p = 0; p < PE; p++) begin
      acc_sum[p] = acc[p] + (core_zero ? 0 : dot(core_w, core_a, p));
      res_pack[p*ACC +: ACC] = acc_sum[p][ACC-1:0];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PE; p++) acc[p] <= 0;
      for (int i = 0; i < 5; i++) begin pipe_v[i] <= 1'b0; pipe_d[i] <= '0; end
    end else if (core_en) begin
      for (int p = 0; p < PE; p++) acc[p] <= core_last ? 0 : acc_sum[p];
      pipe_v[0] <= core_last;
      pipe_d[0] <= res_pack;
      for (int i = 1; i < 5; i++) begin pipe_v[i] <= pipe_v[i-1]; pipe_d[i] <= pipe_d[i-1]; end
    end
  end

  assign core_vld = pipe_v[4];
  assign core_p   = pipe_d[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int p0, input int p1);
    return {ACC'(p1), ACC'(p0)};
  endfunction

  // Output scoreboard: every accepted result must match the next expected group.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 64'(m_tdata), 64'hDEAD);
      else begin
        $display("out %h expected %h", m_tdata, exp_q[0]);
        chk("out_data", 64'(m_tdata), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    int t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin @(posedge clk); #1; t++; end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  // Issues max_slots slots of one vector; inserts gap_len bubbles before slot gap_slot.
  task automatic send_vec(input logic [WW-1:0] w, input logic [VW-1:0] vec,
                          input int gap_slot, input int gap_len, input int max_slots);
    int slot = 0, gap = 0, budget = 0;
    logic [AW-1:0] word;
    while (slot < max_slots && budget < 400) begin
      word = vec[(slot%SF)*AW +: AW];
      if (slot == gap_slot && gap < gap_len) begin
        s_w_tvalid = 0; s_a_tvalid = 0;
      end else begin
        s_w_tvalid = 1; s_a_tvalid = (slot < SF); s_w_tdata = w; s_a_tdata = word;
      end
      @(negedge clk);
      if (slot == gap_slot && gap < gap_len) begin
        chk("bubble_zero", 64'(core_zero), 64'd1);
        chk("bubble_wready", 64'(s_w_tready), 64'd0);
        gap++;
      end else if (s_w_tready) begin
        $display("slot %0d a=%h last=%b", slot, core_a, core_last);
        chk("slot_last", 64'(core_last), 64'((slot % SF) == SF - 1));
        chk("slot_aready", 64'(s_a_tready), 64'(slot < SF));
        chk("slot_a", 64'(core_a), 64'(word));
        chk("slot_zero", 64'(core_zero), 64'd0);
        slot++;
      end
      @(posedge clk); #1;
      budget++;
    end
    chk("send_complete", 64'(slot), 64'(max_slots));
    s_w_tvalid = 0; s_a_tvalid = 0;
  endtask

  typedef struct {
    logic          sw, sa;
    logic [AW-1:0] a;
    logic          e_wr, e_ar, e_zero, e_last, e_mv;
    logic [AW-1:0] e_a;
    logic [PW-1:0] e_md;
  } vec_t;

  localparam logic [WW-1:0] W_ONES   = {8'd1, 8'd1, 8'd1, 8'd1};
  localparam logic [WW-1:0] W_NEG2   = {8'd2, 8'd2, 8'hFF, 8'hFF};
  localparam logic [WW-1:0] W_ONETWO = {8'd2, 8'd2, 8'd1, 8'd1};

  vec_t tbl [11];
  logic [PW-1:0] held;

  initial begin
    tbl[0]  = '{1, 1, 16'h0201, 1, 1, 0, 0, 0, 16'h0201, '0};
    tbl[1]  = '{1, 1, 16'h0403, 1, 1, 0, 1, 0, 16'h0403, '0};
    tbl[2]  = '{1, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0201, '0};
    tbl[3]  = '{1, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0403, '0};
    tbl[4]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, '0};
    tbl[5]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, '0};
    tbl[6]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, '0};
    tbl[7]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, mk(10, 10)};
    tbl[8]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, '0};
    tbl[9]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, mk(10, 10)};
    tbl[10] = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, '0};

    // Reset state, with both streams offering data.
    rst = 1; s_w_tvalid = 1; s_a_tvalid = 1; s_w_tdata = W_ONES;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wready", 64'(s_w_tready), 64'd0);
    chk("rst_aready", 64'(s_a_tready), 64'd0);
    chk("rst_zero", 64'(core_zero), 64'd1);
    chk("rst_last", 64'(core_last), 64'd0);
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mdata", 64'(m_tdata), 64'd0);
    s_w_tvalid = 0; s_a_tvalid = 0;
    @(posedge clk); #1 rst = 0;

    // 1: cycle-accurate table, including 6-cycle last-to-valid latency.
    exp_q.push_back(mk(10, 10)); exp_q.push_back(mk(10, 10));
    s_w_tdata = W_ONES; m_tready = 1;
    for (int i = 0; i < 11; i++) begin
      s_w_tvalid = tbl[i].sw; s_a_tvalid = tbl[i].sa; s_a_tdata = tbl[i].a;
      @(negedge clk);
      $display("tbl %0d wr=%b ar=%b z=%b l=%b a=%h mv=%b md=%h",
               i, s_w_tready, s_a_tready, core_zero, core_last, core_a, m_tvalid, m_tdata);
      chk("tbl_wready", 64'(s_w_tready), 64'(tbl[i].e_wr));
      chk("tbl_aready", 64'(s_a_tready), 64'(tbl[i].e_ar));
      chk("tbl_zero", 64'(core_zero), 64'(tbl[i].e_zero));
      chk("tbl_last", 64'(core_last), 64'(tbl[i].e_last));
      chk("tbl_a", 64'(core_a), 64'(tbl[i].e_a));
      chk("tbl_mvalid", 64'(m_tvalid), 64'(tbl[i].e_mv));
      if (tbl[i].e_mv) chk("tbl_mdata", 64'(m_tdata), 64'(tbl[i].e_md));
      @(posedge clk); #1;
    end
    wait_drain(50);

    // 2: signed weights against full-scale unsigned activations.
    exp_q.push_back(mk(-1020, 2040)); exp_q.push_back(mk(-1020, 2040));
    send_vec(W_NEG2, 32'hFFFFFFFF, -1, 0, NF*SF);
    wait_drain(50);

    // 3: three bubbles in the middle of fold 0.
    exp_q.push_back(mk(10, 10)); exp_q.push_back(mk(10, 10));
    send_vec(W_ONES, 32'h04030201, 1, 3, NF*SF);
    wait_drain(50);

    // 4: downstream held off for 10 cycles while a second vector is waiting.
    exp_q.push_back(mk(10, 10)); exp_q.push_back(mk(10, 10));
    exp_q.push_back(mk(26, 26)); exp_q.push_back(mk(26, 26));
    m_tready = 0;
    fork
      begin
        send_vec(W_ONES, 32'h04030201, -1, 0, NF*SF);
        send_vec(W_ONES, 32'h08070605, -1, 0, NF*SF);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!m_tvalid && t < 100) begin @(negedge clk); t++; end
        chk("stall_seen", 64'(m_tvalid), 64'd1);
        held = m_tdata;
        for (int i = 0; i < 10; i++) begin
          chk("stall_en", 64'(core_en), 64'd0);
          chk("stall_wready", 64'(s_w_tready), 64'd0);
          chk("stall_aready", 64'(s_a_tready), 64'd0);
          chk("stall_hold", 64'(m_tdata), 64'(held));
          @(negedge clk);
        end
        @(posedge clk); #1 m_tready = 1;
      end
    join
    wait_drain(80);

    // 5: reset with sf = 1, nf = 1; the discarded partial vector must not surface.
    send_vec(W_ONES, 32'h04030201, -1, 0, 3);
    rst = 1; s_w_tvalid = 1; s_a_tvalid = 1; s_a_tdata = 16'h0202;
    @(negedge clk);
    chk("mid_rst_wready", 64'(s_w_tready), 64'd0);
    chk("mid_rst_zero", 64'(core_zero), 64'd1);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("post_rst_nf0", 64'(s_a_tready), 64'd1);
    chk("post_rst_sf0", 64'(core_last), 64'd0);
    s_w_tvalid = 0; s_a_tvalid = 0;
    @(posedge clk); #1;
    exp_q.push_back(mk(8, 8)); exp_q.push_back(mk(8, 8));
    send_vec(W_ONES, 32'h02020202, -1, 0, NF*SF);
    wait_drain(50);

    // 6: three vectors under a toggling m_tready; PE1 weights doubled to check lane order.
    exp_q.push_back(mk(4, 8));   exp_q.push_back(mk(4, 8));
    exp_q.push_back(mk(30, 60)); exp_q.push_back(mk(30, 60));
    exp_q.push_back(mk(20, 40)); exp_q.push_back(mk(20, 40));
    fork
      begin
        send_vec(W_ONETWO, 32'h01010101, -1, 0, NF*SF);
        send_vec(W_ONETWO, 32'h06070809, -1, 0, NF*SF);
        send_vec(W_ONETWO, 32'h08060402, -1, 0, NF*SF);
      end
      begin
        int t = 0;
        while (exp_q.size() != 0 && t < 600) begin
          @(posedge clk); #1 m_tready = ~m_tready; t++;
        end
        m_tready = 1;
      end
    join
    wait_drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
